// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: validates one request at a time, drives the data
// SRAM for one cycle, and returns a registered, extended response with an error code.
module mem_access_unit #(
  parameter int ADDR_W           = 16,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic [4:0]        rsp_rd_q;
  logic [1:0]        rsp_err_q;

  logic              accept;
  logic [2:0]        size_m1;
  logic [ADDR_W:0]   last_byte;
  logic              illegal, out_of_range, misaligned;
  logic [1:0]        err_d;
  logic [3:0]        wen_d;
  logic [31:0]       load_ext;

  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;

  always_comb begin
    size_m1      = 3'd0;
    wen_d        = 4'b0001;
    case (req_funct3[1:0])
      2'b01:   begin size_m1 = 3'd1; wen_d = 4'b0011; end
      2'b10:   begin size_m1 = 3'd3; wen_d = 4'b1111; end
      default: begin size_m1 = 3'd0; wen_d = 4'b0001; end
    endcase
    illegal      = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                   (req_funct3 == 3'b111) | (req_funct3[2] & req_we);
    // The carry out of the last-byte sum catches accesses that would wrap past the top.
    last_byte    = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(size_m1);
    out_of_range = ((req_addr >> ADDR_W) != 32'd0) | last_byte[ADDR_W];
    misaligned   = !ALLOW_MISALIGNED &&
                   (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    if (illegal)           err_d = 2'b11;
    else if (out_of_range) err_d = 2'b10;
    else if (misaligned)   err_d = 2'b01;
    else                   err_d = 2'b00;
  end

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{sram_read_data[7]}}, sram_read_data[7:0]};
      3'b100:  load_ext = {24'h0, sram_read_data[7:0]};
      3'b001:  load_ext = {{16{sram_read_data[15]}}, sram_read_data[15:0]};
      3'b101:  load_ext = {16'h0, sram_read_data[15:0]};
      default: load_ext = sram_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      wen_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= '0;
    end else begin
      case (state_q)
        ACCESS: begin
          wen_q       <= '0;
          rsp_rdata_q <= we_q ? 32'h0 : load_ext;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: begin
          if (accept) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr[ADDR_W-1:0];
            wdata_q     <= req_wdata;
            rsp_rd_q    <= req_rd;
            rsp_rdata_q <= '0;
            rsp_err_q   <= err_d;
            if (err_d != 2'b00) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              rsp_valid_q <= 1'b0;
              wen_q       <= req_we ? wen_d : 4'b0000;
              state_q     <= ACCESS;
            end
          end else if (state_q == RESP && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign sram_w_en       = wen_q & {4{~rst}};
  assign sram_address    = addr_q;
  assign sram_write_data = wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_rd          = rsp_rd_q;
  assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (strict and misaligned-tolerant alignment),
// each with its own byte SRAM, checked against a byte-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [4:0]  req_rd    [2];
  logic [3:0]  w_en      [2];
  logic [15:0] s_addr    [2];
  logic [31:0] s_wdata   [2];
  logic [31:0] s_rdata   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic [4:0]  rsp_rd    [2];
  logic [1:0]  rsp_err   [2];

  logic [7:0]  mem0  [65536];
  logic [7:0]  mem1  [65536];
  logic [7:0]  model [2][65536];
  bit          inited = 1'b0;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_rd(req_rd[0]), .sram_w_en(w_en[0]), .sram_address(s_addr[0]),
    .sram_write_data(s_wdata[0]), .sram_read_data(s_rdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_rd(rsp_rd[0]), .rsp_err(rsp_err[0])
  );

  mem_access_unit #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_rd(req_rd[1]), .sram_w_en(w_en[1]), .sram_address(s_addr[1]),
    .sram_write_data(s_wdata[1]), .sram_read_data(s_rdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_rd(rsp_rd[1]), .rsp_err(rsp_err[1])
  );

  assign s_rdata[0] = {mem0[s_addr[0]+16'd3], mem0[s_addr[0]+16'd2],
                       mem0[s_addr[0]+16'd1], mem0[s_addr[0]]};
  assign s_rdata[1] = {mem1[s_addr[1]+16'd3], mem1[s_addr[1]+16'd2],
                       mem1[s_addr[1]+16'd1], mem1[s_addr[1]]};

  always @(posedge clk) begin
    if (!inited) begin
      for (int a = 0; a < 65536; a++) mem0[a] <= 8'(a * 37 + 11);
      inited <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (w_en[0][k]) mem0[s_addr[0] + 16'(k)] <= s_wdata[0][8*k +: 8];
    end
  end

  always @(posedge clk) begin
    if (!inited) begin
      for (int a = 0; a < 65536; a++) mem1[a] <= 8'(a * 37 + 11);
    end else begin
      for (int k = 0; k < 4; k++)
        if (w_en[1][k]) mem1[s_addr[1] + 16'(k)] <= s_wdata[1][8*k +: 8];
    end
  end

  function automatic logic [7:0] sram_byte(input int u, input int a);
    return (u == 1) ? mem1[a] : mem0[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] exp_err(input int u, input logic we,
                                         input logic [2:0] f3, input logic [31:0] addr);
    longint a  = longint'(addr);
    int     sz = size_of(f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && (f3 == 3'd4 || f3 == 3'd5)))
      return 2'b11;
    if (a + sz > 65536) return 2'b10;
    if (u == 0 && ((sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0))) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input int u, input logic [2:0] f3, input int a);
    int     sz = size_of(f3);
    longint v  = 0;
    for (int k = sz - 1; k >= 0; k--) v = v * 256 + longint'(model[u][a + k]);
    if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  // Caller is at a negedge; the DUT is idle or holding a response with rsp_ready high.
  task automatic txn(input int u, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input int stall);
    logic [1:0]  e;
    logic [31:0] ed;
    logic [3:0]  mask;
    int          sz, cnt;
    e  = exp_err(u, we, f3, addr);
    sz = size_of(f3);
    mask = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
    req_valid[u] = 1'b1; req_we[u] = we; req_funct3[u] = f3;
    req_addr[u] = addr; req_wdata[u] = wd; req_rd[u] = rd; rsp_ready[u] = 1'b1;
    #1;
    chk("req_ready_at_offer", req_ready[u], 1'b1);
    cnt = 0;
    while (!req_ready[u] && cnt < 20) begin @(negedge clk); #1; cnt++; end
    if (!req_ready[u]) begin
      chk("accept_timeout", 1'b0, 1'b1);
      req_valid[u] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    if (stall > 0) rsp_ready[u] = 1'b0;
    ed = 32'h0;
    if (e == 2'b00 && !we) ed = exp_load(u, f3, int'(addr));
    if (e == 2'b00 && we)
      for (int k = 0; k < sz; k++) model[u][int'(addr) + k] = wd[8*k +: 8];
    @(negedge clk);
    if (e != 2'b00) begin
      chk("err_rsp_valid_n1", rsp_valid[u], 1'b1);
      chk("err_no_wen", w_en[u], 4'b0000);
    end else begin
      chk("access_rsp_valid_low", rsp_valid[u], 1'b0);
      chk("access_wen", w_en[u], we ? mask : 4'b0000);
      chk("access_addr", s_addr[u], addr[15:0]);
      if (we) chk("access_wdata", s_wdata[u], wd);
      @(negedge clk);
      chk("rsp_valid_n2", rsp_valid[u], 1'b1);
      chk("rsp_wen_idle", w_en[u], 4'b0000);
    end
    chk("rsp_err", rsp_err[u], e);
    chk("rsp_rd", rsp_rd[u], rd);
    chk("rsp_rdata", rsp_rdata[u], ed);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid[u], 1'b1);
      chk("stall_req_ready", req_ready[u], 1'b0);
      chk("stall_rdata", rsp_rdata[u], ed);
      chk("stall_err", rsp_err[u], e);
      chk("stall_rd", rsp_rd[u], rd);
    end
    rsp_ready[u] = 1'b1;
  endtask

  initial begin
    int          u, sel;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; req_rd[i] = 5'd0; rsp_ready[i] = 1'b1;
      for (int x = 0; x < 65536; x++) model[i][x] = 8'(x * 37 + 11);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rsp_valid", rsp_valid[i], 1'b0);
      chk("reset_rsp_rdata", rsp_rdata[i], 32'h0);
      chk("reset_rsp_rd", rsp_rd[i], 5'd0);
      chk("reset_rsp_err", rsp_err[i], 2'b00);
      chk("reset_wen", w_en[i], 4'b0000);
      chk("reset_sram_addr", s_addr[i], 16'h0);
      chk("reset_sram_wdata", s_wdata[i], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1, 0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 5'd2, 0);
    chk("lw_deadbeef", rsp_rdata[0], 32'hDEADBEEF);
    txn(0, 1'b1, 3'd0, 32'h20, 32'h80, 5'd3, 0);
    txn(0, 1'b1, 3'd1, 32'h22, 32'h7FFE, 5'd4, 0);
    txn(0, 1'b0, 3'd0, 32'h20, 32'h0, 5'd5, 0);
    chk("lb_sign", rsp_rdata[0], 32'hFFFFFF80);
    txn(0, 1'b0, 3'd4, 32'h20, 32'h0, 5'd6, 0);
    chk("lbu_zero", rsp_rdata[0], 32'h00000080);
    txn(0, 1'b0, 3'd1, 32'h22, 32'h0, 5'd7, 0);
    chk("lh_pos", rsp_rdata[0], 32'h00007FFE);
    txn(0, 1'b0, 3'd2, 32'h13, 32'h0, 5'd8, 0);
    chk("lw_misaligned_err", rsp_err[0], 2'b01);
    txn(1, 1'b0, 3'd2, 32'h13, 32'h0, 5'd8, 0);
    chk("lw_misaligned_ok", rsp_err[1], 2'b00);
    txn(0, 1'b0, 3'd2, 32'hFFFE, 32'h0, 5'd9, 0);
    txn(0, 1'b0, 3'd2, 32'hFFFC, 32'h0, 5'd10, 0);
    txn(0, 1'b0, 3'd4, 32'hFFFF, 32'h0, 5'd11, 0);
    txn(0, 1'b1, 3'd2, 32'h00010000, 32'hCAFEF00D, 5'd12, 0);
    for (int k = 0; k < 4; k++) chk("range_no_write", sram_byte(0, k), model[0][k]);
    txn(0, 1'b1, 3'd4, 32'h30, 32'h11, 5'd13, 0);
    txn(0, 1'b0, 3'd3, 32'h30, 32'h0, 5'd14, 0);

    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 5'd15, 5);
    txn(0, 1'b1, 3'd1, 32'h24, 32'h0000A5A5, 5'd16, 0);
    txn(0, 1'b0, 3'd5, 32'h24, 32'h0, 5'd17, 3);
    txn(0, 1'b0, 3'd6, 32'h24, 32'h0, 5'd18, 0);

    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2;
    req_addr[0] = 32'h40; req_wdata[0] = 32'h12345678; req_rd[0] = 5'd19;
    #1;
    chk("rst_req_ready", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_access_wen", w_en[0], 4'b0000);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid[0], 1'b0);
    chk("rst_idle_ready", req_ready[0], 1'b1);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("rst_no_write", sram_byte(0, 32'h40 + k), model[0][32'h40 + k]);
    txn(0, 1'b0, 3'd2, 32'h40, 32'h0, 5'd20, 0);

    for (int i = 0; i < 250; i++) begin
      u   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = $urandom_range(0, 63);
      else if (sel < 9) a = 32'hFFF8 + $urandom_range(0, 7);
      else              a = $urandom;
      txn(u, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          5'($urandom_range(0, 31)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
